// File: rtl/mem_slot_sched.sv
// Time-slot arbiter for the shared 16-bit RAM/ROM bus: 4-tick slots alternating
// dedicated CPU slots with shared slots (video > sound > disk > cpu).
module mem_slot_sched #(
    parameter int VID_WORDS  = 32,
    parameter int SLOT_TICKS = 4
) (
    input  logic       clk32,
    input  logic       _systemReset,
    input  logic       clk8_en_p,
    input  logic       clk8_en_n,
    input  logic       _hblank,
    input  logic       _vblank,
    input  logic       cpuReq,
    input  logic       dskReqInt,
    input  logic       dskReqExt,
    output logic       cpuBusControl,
    output logic       videoBusControl,
    output logic [2:0] busOwner,
    output logic       memoryLatch,
    output logic       loadPixels,
    output logic       loadSound,
    output logic       dskReadAckInt,
    output logic       dskReadAckExt,
    output logic       cpuCycleDone
);

    localparam logic [2:0] OWN_IDLE  = 3'd0;
    localparam logic [2:0] OWN_CPU   = 3'd1;
    localparam logic [2:0] OWN_VIDEO = 3'd2;
    localparam logic [2:0] OWN_SOUND = 3'd3;
    localparam logic [2:0] OWN_DSKI  = 3'd4;
    localparam logic [2:0] OWN_DSKE  = 3'd5;

    localparam logic [1:0] PH_LAST = 2'(SLOT_TICKS - 1);
    localparam logic [5:0] VID_MAX = 6'(VID_WORDS);

    typedef struct packed {
        logic [2:0] owner;
        logic       cpu;
        logic       video;
    } grant_t;

    logic [1:0] ph;
    logic       slotSel;
    logic [5:0] vidCount;
    logic       sndPending;
    logic       lastDisk;   // 1: internal drive got the most recent disk grant
    logic       hblank_q;
    logic       slot_start;
    logic       hblank_fall;
    logic       vid_ok;
    grant_t     nxt;

    assign slot_start  = clk8_en_p && (ph == PH_LAST);
    assign hblank_fall = clk8_en_p && hblank_q && !_hblank;
    // Video qualifies on the same registered hblank sample the edge detector
    // uses, so a grant and an hblank clear can land on one tick.
    assign vid_ok      = _vblank && hblank_q && (vidCount < VID_MAX);

    always_comb begin
        nxt.owner = OWN_IDLE;
        if (!slotSel) begin
            if (cpuReq) nxt.owner = OWN_CPU;
        end else if (vid_ok) begin
            nxt.owner = OWN_VIDEO;
        end else if (sndPending) begin
            nxt.owner = OWN_SOUND;
        end else if (dskReqInt && dskReqExt) begin
            nxt.owner = lastDisk ? OWN_DSKE : OWN_DSKI;
        end else if (dskReqInt) begin
            nxt.owner = OWN_DSKI;
        end else if (dskReqExt) begin
            nxt.owner = OWN_DSKE;
        end else if (cpuReq) begin
            nxt.owner = OWN_CPU;
        end
        nxt.cpu   = (nxt.owner == OWN_CPU);
        nxt.video = (nxt.owner == OWN_VIDEO);
    end

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            ph              <= 2'd0;
            slotSel         <= 1'b0;
            busOwner        <= OWN_IDLE;
            cpuBusControl   <= 1'b0;
            videoBusControl <= 1'b0;
            vidCount        <= 6'd0;
            sndPending      <= 1'b0;
            lastDisk        <= 1'b0;
            hblank_q        <= 1'b0;
        end else begin
            if (clk8_en_p) begin
                ph       <= ph + 2'd1;
                hblank_q <= _hblank;
                if (ph == PH_LAST) slotSel <= ~slotSel;
            end

            if (slot_start) begin
                busOwner        <= nxt.owner;
                cpuBusControl   <= nxt.cpu;
                videoBusControl <= nxt.video;
                if (nxt.owner == OWN_DSKI) lastDisk <= 1'b1;
                if (nxt.owner == OWN_DSKE) lastDisk <= 1'b0;
            end

            if (hblank_fall)
                vidCount <= 6'd0;
            else if (slot_start && nxt.video && vidCount != VID_MAX)
                vidCount <= vidCount + 6'd1;

            if (hblank_fall)
                sndPending <= 1'b1;
            else if (slot_start && nxt.owner == OWN_SOUND)
                sndPending <= 1'b0;
        end
    end

    // Data is valid mid-way through the third tick of an owned slot.
    assign memoryLatch   = clk8_en_n && (ph == 2'd2) && (busOwner != OWN_IDLE);
    assign loadPixels    = memoryLatch && (busOwner == OWN_VIDEO);
    assign loadSound     = memoryLatch && (busOwner == OWN_SOUND);
    assign dskReadAckInt = memoryLatch && (busOwner == OWN_DSKI);
    assign dskReadAckExt = memoryLatch && (busOwner == OWN_DSKE);
    assign cpuCycleDone  = memoryLatch && (busOwner == OWN_CPU);

endmodule

// File: tb/tb_mem_slot_sched.sv
// Directed bench for mem_slot_sched: a slot-level vector table plus hand
// sequences for video lines, hblank/sound, disk alternation and mid-slot reset.
module tb_mem_slot_sched;

    logic       clk32 = 1'b0;
    logic       _systemReset;
    logic       clk8_en_p, clk8_en_n;
    logic       _hblank, _vblank;
    logic       cpuReq, dskReqInt, dskReqExt;
    logic       cpuBusControl, videoBusControl;
    logic [2:0] busOwner;
    logic       memoryLatch, loadPixels, loadSound;
    logic       dskReadAckInt, dskReadAckExt, cpuCycleDone;

    mem_slot_sched dut (
        .clk32          (clk32),
        ._systemReset   (_systemReset),
        .clk8_en_p      (clk8_en_p),
        .clk8_en_n      (clk8_en_n),
        ._hblank        (_hblank),
        ._vblank        (_vblank),
        .cpuReq         (cpuReq),
        .dskReqInt      (dskReqInt),
        .dskReqExt      (dskReqExt),
        .cpuBusControl  (cpuBusControl),
        .videoBusControl(videoBusControl),
        .busOwner       (busOwner),
        .memoryLatch    (memoryLatch),
        .loadPixels     (loadPixels),
        .loadSound      (loadSound),
        .dskReadAckInt  (dskReadAckInt),
        .dskReadAckExt  (dskReadAckExt),
        .cpuCycleDone   (cpuCycleDone)
    );

    always #5 clk32 = ~clk32;

    typedef struct {
        logic cpu;
        logic di;
        logic de;
        int   mode;   // 0 none, 1 drop cpuReq mid-slot
        int   exp;    // expected owner of this slot
    } vec_t;

    vec_t tbl[20];

    int n_cmp = 0, n_bad = 0;
    int tcnt = 0;
    int slot_no = 0;
    int tot_pix = 0;
    int n_ml, n_pix, n_snd, n_ai, n_ae, n_cd, n_orphan;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clk32 cycle: enables change on the falling edge, outputs sampled 1ns later.
    task automatic cyc();
        @(negedge clk32);
        clk8_en_p = (tcnt == 0);
        clk8_en_n = (tcnt == 2);
        tcnt = (tcnt + 1) % 4;
        #1;
        if (memoryLatch)   n_ml++;
        if (loadPixels)    n_pix++;
        if (loadSound)     n_snd++;
        if (dskReadAckInt) n_ai++;
        if (dskReadAckExt) n_ae++;
        if (cpuCycleDone)  n_cd++;
        if ((loadPixels | loadSound | dskReadAckInt | dskReadAckExt | cpuCycleDone) && !memoryLatch)
            n_orphan++;
    endtask

    // Runs one slot starting on its slot-start tick and checks ownership and strobes.
    task automatic run_slot(input int exp, input int mode, input string tag);
        int own = 0, stable = 1, cbc = 0, vbc = 0;
        string t;
        t = $sformatf("%s#%0d", tag, slot_no);
        n_ml = 0; n_pix = 0; n_snd = 0; n_ai = 0; n_ae = 0; n_cd = 0; n_orphan = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i == 1) begin
                own = int'(busOwner);
                cbc = int'(cpuBusControl);
                vbc = int'(videoBusControl);
            end else if (i > 1 && int'(busOwner) != own) begin
                stable = 0;
            end
            if (mode == 1 && i == 2) cpuReq = 1'b0;
            if (mode == 2 && i == 2) _hblank = 1'b1;
            if (mode == 2 && i == 6) _hblank = 1'b0;
        end
        check({t, ".owner"},  own, exp);
        check({t, ".stable"}, stable, 1);
        check({t, ".latch"},  n_ml, (exp != 0) ? 1 : 0);
        check({t, ".cpuDone"}, n_cd,  (exp == 1) ? 1 : 0);
        check({t, ".pixels"},  n_pix, (exp == 2) ? 1 : 0);
        check({t, ".sound"},   n_snd, (exp == 3) ? 1 : 0);
        check({t, ".ackInt"},  n_ai,  (exp == 4) ? 1 : 0);
        check({t, ".ackExt"},  n_ae,  (exp == 5) ? 1 : 0);
        check({t, ".cpuBC"},   cbc,   (exp == 1) ? 1 : 0);
        check({t, ".vidBC"},   vbc,   (exp == 2) ? 1 : 0);
        check({t, ".orphan"},  n_orphan, 0);
        tot_pix += n_pix;
        slot_no++;
    endtask

    // Expects _systemReset low; releases it so the next cycle is the first
    // clk8_en_p tick, then checks the idle partial slot before the first slot start.
    task automatic reset_release(input string tag);
        int nz = 0;
        repeat (2) cyc();
        clk8_en_p = 1'b0;
        clk8_en_n = 1'b0;
        tcnt = 0;
        _systemReset = 1'b1;
        n_ml = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (busOwner != 3'd0 || cpuBusControl || videoBusControl) nz++;
        end
        check({tag, ".idle_owner"}, nz, 0);
        check({tag, ".idle_latch"}, n_ml, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 0, 4};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 0, 1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 0, 5};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 0, 4};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 0, 5};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 0, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 0, 4};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 0, 1};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 0, 4};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 0, 0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 0, 0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1, 1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 0, 0};

        _systemReset = 1'b0;
        clk8_en_p = 1'b0; clk8_en_n = 1'b0;
        _hblank = 1'b0; _vblank = 1'b0;
        cpuReq = 1'b1; dskReqInt = 1'b0; dskReqExt = 1'b0;

        repeat (3) cyc();
        check("rst.owner",   int'(busOwner), 0);
        check("rst.cpuBC",   int'(cpuBusControl), 0);
        check("rst.vidBC",   int'(videoBusControl), 0);
        check("rst.latch",   int'(memoryLatch), 0);
        reset_release("por");

        // Blanking: CPU, idle and disk arbitration
        for (int i = 0; i < 20; i++) begin
            cpuReq = tbl[i].cpu; dskReqInt = tbl[i].di; dskReqExt = tbl[i].de;
            run_slot(tbl[i].exp, tbl[i].mode, "tbl");
        end

        // Active line: 32 video fetches interleaved with CPU, then saturation
        _vblank = 1'b1; _hblank = 1'b1; cpuReq = 1'b1;
        dskReqInt = 1'b0; dskReqExt = 1'b0;
        tot_pix = 0;
        for (int j = 0; j < 32; j++) begin
            run_slot(1, 0, "line_cpu");
            run_slot(2, 0, "line_vid");
        end
        check("line.total_pixels", tot_pix, 32);
        for (int j = 0; j < 2; j++) begin
            run_slot(1, 0, "sat_cpu");
            run_slot(1, 0, "sat_shared");
        end

        // hblank falls, pulses again before the grant: one sound fetch only
        _hblank = 1'b0;
        run_slot(1, 2, "hb_fall");
        run_slot(3, 0, "snd");
        run_slot(1, 0, "snd_cpu");
        run_slot(1, 0, "snd_once");

        // hblank falls on the tick of a video grant: count must restart at 0
        _hblank = 1'b1;
        run_slot(1, 0, "col_cpu");
        run_slot(2, 0, "col_vid");
        run_slot(1, 0, "col_cpu");
        run_slot(2, 0, "col_vid");
        run_slot(1, 0, "col_cpu");
        _hblank = 1'b0;
        run_slot(2, 0, "hb_on_vid");
        _hblank = 1'b1;
        tot_pix = 0;
        for (int j = 0; j < 32; j++) begin
            run_slot(1, 0, "l2_cpu");
            run_slot(2, 0, "l2_vid");
        end
        check("line2.total_pixels", tot_pix, 32);
        run_slot(1, 0, "l2_cpu");
        run_slot(3, 0, "snd_after_line");

        // Reset in the middle of a video slot
        _hblank = 1'b0;
        run_slot(1, 0, "pre_cpu");
        _hblank = 1'b1;
        run_slot(3, 0, "pre_snd");
        run_slot(1, 0, "pre_cpu");
        for (int i = 0; i < 6; i++) cyc();
        check("midrst.owner_before", int'(busOwner), 2);
        check("midrst.vidBC_before", int'(videoBusControl), 1);
        _systemReset = 1'b0;
        #1;
        check("midrst.owner", int'(busOwner), 0);
        check("midrst.vidBC", int'(videoBusControl), 0);
        check("midrst.cpuBC", int'(cpuBusControl), 0);
        check("midrst.latch", int'(memoryLatch), 0);
        reset_release("midrst");
        run_slot(1, 0, "post_rst_cpu");
        run_slot(2, 0, "post_rst_vid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
